// File: rtl/lcd_pkg.sv
// lcd_pkg: shared definitions for the HD44780-style LCD bus driver.
//   - lcd_state_e : driver FSM states (poll states only with LCD_BUSY_POLL_EN)
//   - CMD_CLEAR / CMD_HOME : commands that need the long post-write wait
//   - DEF_T_*_CYC : default timing constants in clock cycles
//   - eff_cyc / max_u : helpers for deriving counter loads and widths
package lcd_pkg;

  localparam int unsigned DEF_T_SETUP_CYC = 4;
  localparam int unsigned DEF_T_EN_CYC    = 12;
  localparam int unsigned DEF_T_HOLD_CYC  = 4;
  localparam int unsigned DEF_T_EXEC_CYC  = 2000;
  localparam int unsigned DEF_T_CLEAR_CYC = 82000;

  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME  = 8'h02;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ENABLE,
    ST_HOLD,
`ifdef LCD_BUSY_POLL_EN
    ST_POLL_SETUP,
    ST_POLL_EN,
    ST_POLL_HOLD,
`endif
    ST_WAIT
  } lcd_state_e;

  // A zero-length phase still occupies one clock.
  function automatic int unsigned eff_cyc(input int unsigned v);
    return (v == 0) ? 1 : v;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_bus_driver.sv
// lcd_bus_driver: writes one byte per request to a parallel 8-bit LCD panel,
// sequencing setup / E-pulse / hold, then waiting out the panel's execution
// time before reporting done.
// Optional feature macro: LCD_BUSY_POLL_EN -- replaces the fixed post-write
// wait with busy-flag polling (read cycles, lcd_db_in[7]) and a timeout.
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   data_in, rs_in, start   request byte, register select, one-clock strobe
//   lcd_db_in               panel data bus readback (polling build only)
//   lcd_data, lcd_rs, lcd_rw, lcd_en, lcd_db_oe   panel bus
//   busy, done, overrun     status: in progress, completion pulse, sticky drop
module lcd_bus_driver
  import lcd_pkg::*;
#(
  parameter int unsigned T_SETUP_CYC = DEF_T_SETUP_CYC,
  parameter int unsigned T_EN_CYC    = DEF_T_EN_CYC,
  parameter int unsigned T_HOLD_CYC  = DEF_T_HOLD_CYC,
  parameter int unsigned T_EXEC_CYC  = DEF_T_EXEC_CYC,
  parameter int unsigned T_CLEAR_CYC = DEF_T_CLEAR_CYC
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] data_in,
  input  logic       rs_in,
  input  logic       start,
  input  logic [7:0] lcd_db_in,
  output logic [7:0] lcd_data,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  output logic       lcd_db_oe,
  output logic       busy,
  output logic       done,
  output logic       overrun
);

  localparam int unsigned SETUP_EFF = eff_cyc(T_SETUP_CYC);
  localparam int unsigned EN_EFF    = eff_cyc(T_EN_CYC);
  localparam int unsigned HOLD_EFF  = eff_cyc(T_HOLD_CYC);
  localparam int unsigned EXEC_EFF  = eff_cyc(T_EXEC_CYC);
  localparam int unsigned CLEAR_EFF = eff_cyc(T_CLEAR_CYC);

  // Counter is loaded with (phase length - 1) and counts down to zero.
  localparam int unsigned CNT_MAX = max_u(max_u(max_u(SETUP_EFF, EN_EFF),
                                                max_u(HOLD_EFF, EXEC_EFF)), CLEAR_EFF);
  localparam int unsigned CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_EFF - 1);
  localparam logic [CNT_W-1:0] EN_LD    = CNT_W'(EN_EFF - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_EFF - 1);

  lcd_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       data_q;
  logic             rs_q;

`ifdef LCD_BUSY_POLL_EN
  localparam int unsigned PT_W = $clog2(CLEAR_EFF + 1);
  localparam logic [PT_W-1:0] POLL_TMO = PT_W'(CLEAR_EFF - 1);

  logic [PT_W-1:0] poll_cnt;
  logic            busy_flag;

  wire unused_poll = ^{lcd_db_in[6:0], data_q, rs_q};
`else
  localparam logic [CNT_W-1:0] EXEC_LD  = CNT_W'(EXEC_EFF - 1);
  localparam logic [CNT_W-1:0] CLEAR_LD = CNT_W'(CLEAR_EFF - 1);

  logic [CNT_W-1:0] wait_ld_c;

  // Clear and home need the long execution wait; everything else is short.
  assign wait_ld_c = (!rs_q && (data_q == CMD_CLEAR || data_q == CMD_HOME)) ? CLEAR_LD : EXEC_LD;
  assign lcd_rw    = 1'b0;

  wire unused_db = ^lcd_db_in;
`endif

  // Driver FSM with registered panel and status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      data_q    <= 8'h00;
      rs_q      <= 1'b0;
      lcd_data  <= 8'h00;
      lcd_rs    <= 1'b0;
      lcd_en    <= 1'b0;
      lcd_db_oe <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      overrun   <= 1'b0;
`ifdef LCD_BUSY_POLL_EN
      lcd_rw    <= 1'b0;
      poll_cnt  <= '0;
      busy_flag <= 1'b0;
`endif
    end else begin
      done <= 1'b0;

      // A request while busy is dropped and flagged until reset.
      if (start && busy) overrun <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (start) begin
            data_q    <= data_in;
            rs_q      <= rs_in;
            lcd_data  <= data_in;
            lcd_rs    <= rs_in;
            lcd_db_oe <= 1'b1;
            busy      <= 1'b1;
            cnt       <= SETUP_LD;
            state     <= ST_SETUP;
          end
        end

        ST_SETUP: begin
          if (cnt == '0) begin
            lcd_en <= 1'b1;
            cnt    <= EN_LD;
            state  <= ST_ENABLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        ST_ENABLE: begin
          if (cnt == '0) begin
            lcd_en <= 1'b0;
            cnt    <= HOLD_LD;
            state  <= ST_HOLD;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        ST_HOLD: begin
          if (cnt == '0) begin
            lcd_data  <= 8'h00;
            lcd_rs    <= 1'b0;
            lcd_db_oe <= 1'b0;
`ifdef LCD_BUSY_POLL_EN
            lcd_rw    <= 1'b1;
            poll_cnt  <= '0;
            cnt       <= SETUP_LD;
            state     <= ST_POLL_SETUP;
`else
            cnt       <= wait_ld_c;
            state     <= ST_WAIT;
`endif
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

`ifdef LCD_BUSY_POLL_EN
        ST_POLL_SETUP: begin
          if (cnt == '0) begin
            lcd_en <= 1'b1;
            cnt    <= EN_LD;
            state  <= ST_POLL_EN;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        ST_POLL_EN: begin
          if (cnt == '0) begin
            // Busy flag is sampled in the last E-high cycle.
            busy_flag <= lcd_db_in[7];
            lcd_en    <= 1'b0;
            cnt       <= HOLD_LD;
            state     <= ST_POLL_HOLD;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        ST_POLL_HOLD: begin
          if (cnt == '0) begin
            if (busy_flag) begin
              cnt   <= SETUP_LD;
              state <= ST_POLL_SETUP;
            end else begin
              lcd_rw <= 1'b0;
              done   <= 1'b1;
              busy   <= 1'b0;
              state  <= ST_IDLE;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
`endif

        ST_WAIT: begin
          if (cnt == '0) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        default: state <= ST_IDLE;
      endcase

`ifdef LCD_BUSY_POLL_EN
      // Panel that never clears its busy flag: give up and flag it.
      if (state == ST_POLL_SETUP || state == ST_POLL_EN || state == ST_POLL_HOLD) begin
        poll_cnt <= poll_cnt + PT_W'(1);
        if (poll_cnt == POLL_TMO) begin
          lcd_en  <= 1'b0;
          lcd_rw  <= 1'b0;
          done    <= 1'b1;
          busy    <= 1'b0;
          overrun <= 1'b1;
          cnt     <= '0;
          state   <= ST_IDLE;
        end
      end
`endif
    end
  end

endmodule
